// File: rtl/shared_count_pkg.sv
// shared_count_pkg: shared types and sizes for the shared counter arbiter
package shared_count_pkg;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int STEP_W = 2;
  localparam int ID_W = $clog2(N_REQ);
  typedef logic [STEP_W-1:0] step_t;
  typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/shared_count_arb_if.sv
// shared_count_arb_if: request/grant and ticket response bundle
interface shared_count_arb_if;
  import shared_count_pkg::*;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*STEP_W-1:0] req_step;
  logic [N_REQ-1:0] req_ready;
  logic rsp_valid;
  req_id_t rsp_id;
  logic [WIDTH-1:0] rsp_value;
  logic rsp_wrap;
  modport master(output req_valid, req_step, input req_ready, rsp_valid, rsp_id, rsp_value, rsp_wrap);
  modport slave(input req_valid, req_step, output req_ready, rsp_valid, rsp_id, rsp_value, rsp_wrap);
endinterface

// File: rtl/shared_count_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at i_ptr
module rr_arbiter
  import shared_count_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  req_id_t          i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output req_id_t          o_id
);
  int w_idx;
  // scan from the far end back toward ptr so the last hit is the nearest one
  always_comb begin
    o_gnt = '0;
    o_id = '0;
    w_idx = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N_REQ;
      if (i_en && i_req[w_idx]) begin
        o_gnt = '0;
        o_gnt[w_idx] = 1'b1;
        o_id = req_id_t'(w_idx);
      end
    end
  end
endmodule

// File: rtl/shared_count_arb.sv
// shared_count_arb: round-robin access to one modular ticket counter
module shared_count_arb
  import shared_count_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_limit,
  shared_count_arb_if.slave bus
);
  logic [WIDTH-1:0] r_cnt;
  req_id_t r_ptr;
  logic r_rsp_valid;
  req_id_t r_rsp_id;
  logic [WIDTH-1:0] r_rsp_value;
  logic r_rsp_wrap;
  logic w_en;
  logic [N_REQ-1:0] w_gnt;
  req_id_t w_id;
  logic w_fire;
  step_t w_step;
  logic [WIDTH:0] w_sum;
  logic [WIDTH-1:0] w_sub;
  logic w_over;
  logic w_wrap;
  logic [WIDTH-1:0] w_next;
  assign w_en = i_enable & ~i_clear & rstn;
  rr_arbiter u_arb (.i_req(bus.req_valid), .i_ptr(r_ptr), .i_en(w_en), .o_gnt(w_gnt), .o_id(w_id));
  assign bus.req_ready = w_gnt;
  assign w_fire = |w_gnt;
  assign w_step = bus.req_step[w_id*STEP_W +: STEP_W];
  assign w_sum = {1'b0, r_cnt} + {{(WIDTH + 1 - STEP_W){1'b0}}, w_step};
  // overshoot is below 2^WIDTH, so the low bits of the subtraction are exact
  assign w_sub = w_sum[WIDTH-1:0] - i_limit - WIDTH'(1);
  assign w_over = r_cnt > i_limit;
  assign w_wrap = w_over | (w_sum > {1'b0, i_limit});
  assign w_next = w_over ? '0 : w_wrap ? w_sub : w_sum[WIDTH-1:0];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_ptr <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id <= '0;
      r_rsp_value <= '0;
      r_rsp_wrap <= 1'b0;
    end else begin
      r_rsp_valid <= w_fire;
      if (i_clear) begin
        r_cnt <= '0;
        r_ptr <= '0;
      end else if (w_fire) begin
        r_cnt <= w_next;
        r_ptr <= (w_id == req_id_t'(N_REQ - 1)) ? '0 : w_id + 1'b1;
        r_rsp_id <= w_id;
        r_rsp_value <= r_cnt;
        r_rsp_wrap <= w_wrap;
      end
    end
  end
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id = r_rsp_id;
  assign bus.rsp_value = r_rsp_value;
  assign bus.rsp_wrap = r_rsp_wrap;
endmodule
